fsm_add_subt_ctrl: RTL and testbench

Control FSM for the floating-point add/subtract unit. It sequences the operand-capture stage, exponent difference, alignment shift, mantissa add, normalization and rounding, and the final result register. It is purely control: it drives single-cycle load/shift strobes into the datapath and reacts to status flags returned by it. One operation is in flight at a time, with a ready/acknowledge handshake to the consumer.

---
 rtl/fsm_add_subt_ctrl.sv | 163 ++++++++++++++++
 tb/tb_fsm_add_subt_ctrl.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fsm_add_subt_ctrl.sv
// Sequencing FSM for the floating-point add/subtract datapath.
// Emits one-cycle Moore strobes per stage and hands results off with a ready/ack handshake.
module fsm_add_subt_ctrl #(
    parameter int SW = 24
) (
    input  logic clk,
    input  logic rst,
    input  logic beg_op_i,
    input  logic ack_op_i,
    input  logic zero_flag_i,
    input  logic add_ovf_i,
    input  logic msb_i,
    input  logic round_ovf_i,
    output logic load_a_o,
    output logic load_b_o,
    output logic load_exp_o,
    output logic shift_load_o,
    output logic add_load_o,
    output logic norm_left_o,
    output logic norm_right_o,
    output logic round_load_o,
    output logic load_result_o,
    output logic zero_result_o,
    output logic busy_o,
    output logic ready_o
);

    localparam int CW = (SW > 1) ? $clog2(SW) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(SW - 1);

    typedef enum logic [3:0] {
        IDLE      = 4'd0,
        LOAD_OPER = 4'd1,
        CLASSIFY  = 4'd2,
        ZERO      = 4'd3,
        EXP       = 4'd4,
        ALIGN     = 4'd5,
        ADD       = 4'd6,
        NORM_CHK  = 4'd7,
        NORM_L    = 4'd8,
        NORM_R    = 4'd9,
        ROUND     = 4'd10,
        RND_CHK   = 4'd11,
        RND_R     = 4'd12,
        RESULT    = 4'd13,
        READY     = 4'd14
    } state_t;

    state_t        state;
    state_t        next_state;
    logic [CW-1:0] norm_cnt;
    logic [CW-1:0] next_cnt;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            norm_cnt <= '0;
        end else begin
            state    <= next_state;
            norm_cnt <= next_cnt;
        end
    end

    // A zero count means no left shift has happened yet, which is the only time add_ovf_i matters.
    always_comb begin
        next_state = state;
        next_cnt   = norm_cnt;
        case (state)
            IDLE: begin
                if (beg_op_i) begin
                    next_state = LOAD_OPER;
                end
            end
            LOAD_OPER: next_state = CLASSIFY;
            CLASSIFY: begin
                if (zero_flag_i) begin
                    next_state = ZERO;
                end else begin
                    next_state = EXP;
                end
            end
            ZERO:  next_state = READY;
            EXP:   next_state = ALIGN;
            ALIGN: next_state = ADD;
            ADD: begin
                next_state = NORM_CHK;
                next_cnt   = '0;
            end
            NORM_CHK: begin
                if (add_ovf_i && (norm_cnt == '0)) begin
                    next_state = NORM_R;
                end else if (msb_i) begin
                    next_state = ROUND;
                end else if (norm_cnt == CNT_MAX) begin
                    next_state = ROUND;
                end else begin
                    next_state = NORM_L;
                end
            end
            NORM_L: begin
                next_state = NORM_CHK;
                next_cnt   = norm_cnt + CW'(1);
            end
            NORM_R: next_state = ROUND;
            ROUND:  next_state = RND_CHK;
            RND_CHK: begin
                if (round_ovf_i) begin
                    next_state = RND_R;
                end else begin
                    next_state = RESULT;
                end
            end
            RND_R:  next_state = RESULT;
            RESULT: next_state = READY;
            READY: begin
                if (ack_op_i) begin
                    next_state = IDLE;
                end
            end
            default: begin
                next_state = IDLE;
                next_cnt   = '0;
            end
        endcase
    end

    always_comb begin
        load_a_o      = 1'b0;
        load_b_o      = 1'b0;
        load_exp_o    = 1'b0;
        shift_load_o  = 1'b0;
        add_load_o    = 1'b0;
        norm_left_o   = 1'b0;
        norm_right_o  = 1'b0;
        round_load_o  = 1'b0;
        load_result_o = 1'b0;
        zero_result_o = 1'b0;
        busy_o        = 1'b1;
        ready_o       = 1'b0;
        case (state)
            IDLE:      busy_o = 1'b0;
            LOAD_OPER: load_a_o = 1'b1;
            CLASSIFY:  load_b_o = 1'b1;
            ZERO: begin
                load_result_o = 1'b1;
                zero_result_o = 1'b1;
            end
            EXP:       load_exp_o = 1'b1;
            ALIGN:     shift_load_o = 1'b1;
            ADD:       add_load_o = 1'b1;
            NORM_CHK:  busy_o = 1'b1;
            NORM_L:    norm_left_o = 1'b1;
            NORM_R:    norm_right_o = 1'b1;
            ROUND:     round_load_o = 1'b1;
            RND_CHK:   busy_o = 1'b1;
            RND_R:     norm_right_o = 1'b1;
            RESULT:    load_result_o = 1'b1;
            READY:     ready_o = 1'b1;
            default:   busy_o = 1'b1;
        endcase
    end

endmodule

// File: tb/tb_fsm_add_subt_ctrl.sv
// Scoreboard bench for fsm_add_subt_ctrl: stimulus queues expected strobe events,
// a negedge monitor pops and compares them as the DUT raises strobes.
module tb_fsm_add_subt_ctrl;

    localparam int SW = 24;

    localparam logic [10:0] E_LA  = 11'b100_0000_0000;
    localparam logic [10:0] E_LB  = 11'b010_0000_0000;
    localparam logic [10:0] E_EXP = 11'b001_0000_0000;
    localparam logic [10:0] E_SH  = 11'b000_1000_0000;
    localparam logic [10:0] E_ADD = 11'b000_0100_0000;
    localparam logic [10:0] E_NL  = 11'b000_0010_0000;
    localparam logic [10:0] E_NR  = 11'b000_0001_0000;
    localparam logic [10:0] E_RL  = 11'b000_0000_1000;
    localparam logic [10:0] E_LR  = 11'b000_0000_0100;
    localparam logic [10:0] E_ZR  = 11'b000_0000_0010;
    localparam logic [10:0] E_RDY = 11'b000_0000_0001;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic beg_op_i = 1'b0;
    logic ack_op_i = 1'b0;
    logic zero_flag_i = 1'b0;
    logic add_ovf_i = 1'b0;
    logic msb_i;
    logic round_ovf_i = 1'b0;
    logic load_a_o, load_b_o, load_exp_o, shift_load_o, add_load_o;
    logic norm_left_o, norm_right_o, round_load_o, load_result_o;
    logic zero_result_o, busy_o, ready_o;

    typedef struct {
        string       name;
        int          cyc;
        logic [10:0] vec;
    } ev_t;

    typedef struct {
        string name;
        int    act;
        int    exp;
    } chk_t;

    ev_t  expQ[$];
    chk_t chkQ[$];
    ev_t  cur;
    chk_t curChk;
    logic [10:0] obs;
    logic prevReady = 1'b0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int startCyc = 0;
    int leftSeen = 0;
    int msbAfter = 0;

    fsm_add_subt_ctrl #(.SW(SW)) dut (
        .clk(clk),
        .rst(rst),
        .beg_op_i(beg_op_i),
        .ack_op_i(ack_op_i),
        .zero_flag_i(zero_flag_i),
        .add_ovf_i(add_ovf_i),
        .msb_i(msb_i),
        .round_ovf_i(round_ovf_i),
        .load_a_o(load_a_o),
        .load_b_o(load_b_o),
        .load_exp_o(load_exp_o),
        .shift_load_o(shift_load_o),
        .add_load_o(add_load_o),
        .norm_left_o(norm_left_o),
        .norm_right_o(norm_right_o),
        .round_load_o(round_load_o),
        .load_result_o(load_result_o),
        .zero_result_o(zero_result_o),
        .busy_o(busy_o),
        .ready_o(ready_o)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Datapath stand-in: the normalized MSB appears once the requested number of left shifts is done.
    always @(posedge clk) begin
        if (load_a_o) leftSeen <= 0;
        else if (norm_left_o) leftSeen <= leftSeen + 1;
    end
    assign msb_i = (leftSeen >= msbAfter);

    function automatic int allOut();
        return int'({load_a_o, load_b_o, load_exp_o, shift_load_o, add_load_o, norm_left_o,
                     norm_right_o, round_load_o, load_result_o, zero_result_o, busy_o, ready_o});
    endfunction

    // Monitor: every strobe (and the rising edge of ready) must match the head of the scoreboard.
    always @(negedge clk) begin
        obs = {load_a_o, load_b_o, load_exp_o, shift_load_o, add_load_o, norm_left_o,
               norm_right_o, round_load_o, load_result_o, zero_result_o, ready_o & ~prevReady};
        prevReady = ready_o;
        if (obs != '0) begin
            checks++;
            if (expQ.size() == 0) begin
                errors++;
                $display("[TB] FAIL unexpected_event: got vec=%b at cycle %0d, required no event", obs, cyc - startCyc);
            end else begin
                cur = expQ.pop_front();
                if (cur.vec !== obs || cur.cyc != cyc - startCyc) begin
                    errors++;
                    $display("[TB] FAIL %s: got vec=%b cycle=%0d, required vec=%b cycle=%0d",
                             cur.name, obs, cyc - startCyc, cur.vec, cur.cyc);
                end
            end
        end
        while (chkQ.size() > 0) begin
            curChk = chkQ.pop_front();
            checks++;
            if (curChk.act != curChk.exp) begin
                errors++;
                $display("[TB] FAIL %s: got 0x%0h, required 0x%0h", curChk.name, curChk.act, curChk.exp);
            end
        end
    end

    task automatic checkOutput(input string name, input int act, input int exp);
        chkQ.push_back('{name: name, act: act, exp: exp});
    endtask

    task automatic pushEv(input string name, input int c, input logic [10:0] v);
        expQ.push_back('{name: name, cyc: c, vec: v});
    endtask

    // Expected strobe schedule relative to the edge that samples beg_op_i.
    task automatic pushExpected(input string name, input bit zf, input bit ovf, input int nLeft,
                                input bit rovf, input int readyCyc);
        int cr;
        int cres;
        pushEv({name, "_load_a"}, 1, E_LA);
        pushEv({name, "_load_b"}, 2, E_LB);
        if (zf) begin
            pushEv({name, "_zero_result"}, 3, E_LR | E_ZR);
        end else begin
            pushEv({name, "_load_exp"}, 3, E_EXP);
            pushEv({name, "_shift_load"}, 4, E_SH);
            pushEv({name, "_add_load"}, 5, E_ADD);
            if (ovf) begin
                pushEv({name, "_norm_right"}, 7, E_NR);
                cr = 8;
            end else begin
                for (int k = 0; k < nLeft; k++) pushEv({name, "_norm_left"}, 7 + 2 * k, E_NL);
                cr = 7 + 2 * nLeft;
            end
            pushEv({name, "_round_load"}, cr, E_RL);
            if (rovf) begin
                pushEv({name, "_rnd_right"}, cr + 2, E_NR);
                cres = cr + 3;
            end else begin
                cres = cr + 2;
            end
            pushEv({name, "_load_result"}, cres, E_LR);
        end
        pushEv({name, "_ready"}, readyCyc, E_RDY);
    endtask

    // Called at a negedge with the DUT in IDLE; returns at a negedge with the DUT back in IDLE.
    task automatic applyStimulus(input string name, input bit zf, input bit ovf, input int msbA,
                                 input bit rovf, input int nLeft, input int readyCyc,
                                 input int ackDelay, input bit midBeg);
        bit got;
        zero_flag_i = zf;
        add_ovf_i   = ovf;
        round_ovf_i = rovf;
        msbAfter    = msbA;
        pushExpected(name, zf, ovf, nLeft, rovf, readyCyc);
        beg_op_i = 1'b1;
        startCyc = cyc;
        @(negedge clk);
        beg_op_i = 1'b0;
        checkOutput({name, "_busy_rise"}, int'(busy_o), 1);
        got = 1'b0;
        for (int i = 0; i < 200; i++) begin
            if (ready_o) begin
                got = 1'b1;
                break;
            end
            beg_op_i = midBeg && (i == 2);
            @(negedge clk);
        end
        beg_op_i = 1'b0;
        if (!got) checkOutput({name, "_ready_timeout"}, 0, 1);
        if (ackDelay > 0) begin
            repeat (ackDelay) @(negedge clk);
            checkOutput({name, "_ready_held"}, int'({busy_o, ready_o}), 3);
        end
        ack_op_i = 1'b1;
        @(negedge clk);
        ack_op_i = 1'b0;
        checkOutput({name, "_idle_after_ack"}, int'({busy_o, ready_o}), 0);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached, required $finish earlier");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        $display("[TB] starting fsm_add_subt_ctrl bench");
        @(negedge clk);
        @(negedge clk);
        checkOutput("reset_state", allOut(), 0);
        rst = 1'b1;
        @(negedge clk);

        //            name        zf ovf msbA rovf nLeft ready ack mid
        applyStimulus("nominal",   0, 0,   0,  0,    0,   10,   0, 0);
        applyStimulus("zero",      1, 0,   0,  0,    0,    4,   0, 0);
        applyStimulus("ovf_rnd",   0, 1,   0,  1,    0,   12,   0, 0);
        applyStimulus("shift3",    0, 0,   3,  0,    3,   16,   0, 0);
        applyStimulus("stuck",     0, 0,  99,  0,   23,   56,   0, 0);
        applyStimulus("ovf_nomsb", 0, 1,  99,  0,    0,   11,   0, 0);
        applyStimulus("handshake", 0, 0,   0,  1,    0,   11,  20, 1);
        applyStimulus("zero_ovf",  1, 1,   0,  1,    0,    4,   0, 0);

        // Reset while in the first NORM_L visit of a never-normalizing operation.
        zero_flag_i = 1'b0;
        add_ovf_i   = 1'b0;
        round_ovf_i = 1'b0;
        msbAfter    = 99;
        pushEv("rstop_load_a", 1, E_LA);
        pushEv("rstop_load_b", 2, E_LB);
        pushEv("rstop_load_exp", 3, E_EXP);
        pushEv("rstop_shift_load", 4, E_SH);
        pushEv("rstop_add_load", 5, E_ADD);
        pushEv("rstop_norm_left", 7, E_NL);
        beg_op_i = 1'b1;
        startCyc = cyc;
        @(negedge clk);
        beg_op_i = 1'b0;
        while (cyc - startCyc < 7) @(negedge clk);
        #2 rst = 1'b0;
        #1 checkOutput("reset_midop", allOut(), 0);
        @(negedge clk);
        checkOutput("reset_held", allOut(), 0);
        rst = 1'b1;
        @(negedge clk);

        applyStimulus("after_rst", 0, 0,   0,  0,    0,   10,   0, 0);

        @(negedge clk);
        checkOutput("queue_drained", expQ.size(), 0);
        @(negedge clk);
        @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
